fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage for the five-stage pipeline. It owns the PC, issues word fetches to instruction memory over a request/response interface with at most one request in flight, and presents fetched instructions to the IF/ID register. It consumes the hazard unit's `stall_if` and the EX-stage branch redirect. A one-entry skid buffer keeps throughput at one instruction per cycle with single-cycle memory, including across load-use stalls.

## Interface
- `RESET_PC`, default 32'h0100_0000: first fetch address after reset.
- `AWIDTH`, default 32: PC and address width.
- `clk`  in  1: clock, all state on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall_if`  in  1: from the hazard unit; when high, IF/ID does not accept `f_*` this cycle.
- `br_taken`  in  1: EX-stage taken branch or jump; redirects fetch and flushes wrong-path state.
- `br_target`  in  AWIDTH: redirect address; bits [1:0] are forced to 0 internally.
- `imem_req`  out  1: fetch request, valid for one cycle. Memory always accepts it.
- `imem_addr`  out  AWIDTH: fetch address, meaningful only while `imem_req` is high.
- `imem_rvalid`  in  1: response valid; arrives at least 1 cycle after its request.
- `imem_rdata`  in  32: instruction word returned with `imem_rvalid`.
- `f_valid`  out  1: `f_pc` and `f_insn` hold an instruction for IF/ID.
- `f_pc`  out  AWIDTH: PC of the presented instruction.
- `f_insn`  out  32: presented instruction.

## Operation
- `pc` holds the address of the outstanding request, or of the next request to issue. It is AWIDTH-bit, wraps modulo 2^AWIDTH, and always increments by 4.
- Accept: an instruction is accepted when `f_valid && !stall_if`. Outputs stay stable while `f_valid && stall_if`.
- `out_free` = `!f_valid || !stall_if`.
- States:
  - **ISSUE**: no request outstanding.
    - `imem_req = !br_taken`, `imem_addr = pc`.
    - Go to WAIT if a request issued.
    - On `br_taken`: `pc <= br_target`, stay in ISSUE.
  - **WAIT**: one request outstanding.
    - On `imem_rvalid && !br_taken && out_free`: load `f_* <= {1, pc, imem_rdata}`. In the same cycle assert `imem_req` with `imem_addr = pc+4`, set `pc <= pc+4`, stay in WAIT (back-to-back issue).
    - On `imem_rvalid && !br_taken && !out_free`: load the skid buffer `<= {pc, imem_rdata}`, set `pc <= pc+4`, go to HOLD, no request.
    - On `br_taken` with no `imem_rvalid`: `pc <= br_target`, go to DROP.
    - On `br_taken` with `imem_rvalid`: discard the response, `pc <= br_target`, go to ISSUE.
  - **HOLD**: output register and skid buffer both full, no request outstanding.
    - On accept: `f_* <= skid`, clear the skid buffer, go to ISSUE.
  - **DROP**: the outstanding request is wrong-path.
    - `imem_req = 0`.
    - On `imem_rvalid`: discard the response, go to ISSUE.
    - On `br_taken` in DROP: `pc <= br_target`, stay in DROP until the response arrives.
- `br_taken` has priority over everything else. In every state it clears `f_valid` and the skid buffer in the same edge, and no wrong-path instruction is ever presented.
- An accept with no refill in the same cycle clears `f_valid`.
- `imem_rvalid` in ISSUE or HOLD is a protocol violation and is ignored.

## Timing
- Reset values:
  - State ISSUE, `pc = RESET_PC`.
  - `f_valid = 0`, `f_pc = 0`, `f_insn = 32'h0000_0013` (NOP).
  - Skid buffer empty.
  - `imem_req` low while `rst_n` is low.
- `imem_req` and `imem_addr` are combinational from state, `pc`, `br_taken`, `imem_rvalid` and `stall_if`. `f_*` are registered.
- First request is issued in the first cycle with `rst_n` high.
- Latency: request at cycle t with memory latency L gives the response at t+L and `f_valid` at t+L+1.
- With L=1 and no stalls, one instruction is presented per cycle.
- Redirect: `br_taken` at cycle t gives a request to `br_target` at t+1 if in ISSUE or WAIT with a response in cycle t. Otherwise the request goes out one cycle after the stale response.
- Reset mid-operation clears all state asynchronously. Instruction memory is reset by the same `rst_n`, so no pre-reset response is delivered.

## Test plan
- **Streaming:** release reset, memory L=1 returns `addr^32'hA5A5_0000` → requests at 0x0100_0000, 0x0100_0004, … on consecutive cycles; `f_valid` high every cycle from cycle 2; `f_pc` sequential.
- **Load-use stall:** stall for 3 cycles while streaming → `f_pc` held at 0x0100_0008; the next word is in the skid buffer; no requests during HOLD. On release, 0x0100_0008 then 0x0100_000C are presented on consecutive cycles with no gap or duplicate.
- **Redirect while waiting:** L=4, `br_taken` with `br_target`=0x0100_0203 one cycle after a request → stale response discarded; next request is to 0x0100_0200; `f_valid` stays 0 until that response returns.
- **Redirect during stall/HOLD:** `br_taken` while `stall_if` is high and the skid buffer is full → `f_valid` is 0 and the skid buffer is empty next cycle; request to `br_target` in the following cycle.
- **Wrap and double redirect:** `br_target`=0xFFFF_FFFC → next fetch address is 0x0000_0000. Two `br_taken` pulses in DROP → only the second target is fetched.
- **Mid-stream reset:** assert `rst_n` low mid-stream → outputs return to reset values immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// One request in flight; memory always accepts a request.
interface fetch_unit_if #(
    parameter int unsigned AWIDTH = 32
);
    logic              imem_req;
    logic [AWIDTH-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches one word at a time from imem and
// presents it to IF/ID, with a one-entry skid buffer for stalls.
module fetch_unit #(
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              br_taken,
    input  logic [AWIDTH-1:0] br_target,
    fetch_unit_if.master      imem,
    output logic              f_valid,
    output logic [AWIDTH-1:0] f_pc,
    output logic [31:0]       f_insn
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] pc_next4;
    logic [AWIDTH-1:0] target;
    logic [AWIDTH-1:0] skid_pc;
    logic [31:0]       skid_insn;
    logic              out_free;
    logic              accept;

    assign pc_next4 = pc + AWIDTH'(4);
    assign target   = {br_target[AWIDTH-1:2], 2'b00};
    assign out_free = !f_valid || !stall_if;
    assign accept   = f_valid && !stall_if;

    // WAIT re-issues in the response cycle so L=1 memory streams.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        unique case (state)
            ISSUE: imem.imem_req = rst_n && !br_taken;
            WAIT: begin
                imem.imem_req  = imem.imem_rvalid && !br_taken && out_free;
                imem.imem_addr = pc_next4;
            end
            default: imem.imem_req = 1'b0;
        endcase
    end

    // The skid buffer is full exactly while in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ISSUE;
            pc        <= RESET_PC;
            f_valid   <= 1'b0;
            f_pc      <= '0;
            f_insn    <= NOP;
            skid_pc   <= '0;
            skid_insn <= NOP;
        end else if (br_taken) begin
            pc      <= target;
            f_valid <= 1'b0;
            unique case (state)
                WAIT, DROP: state <= imem.imem_rvalid ? ISSUE : DROP;
                default:    state <= ISSUE;
            endcase
        end else begin
            if (accept) begin
                f_valid <= 1'b0;
            end
            unique case (state)
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        pc <= pc_next4;
                        if (out_free) begin
                            f_valid <= 1'b1;
                            f_pc    <= pc;
                            f_insn  <= imem.imem_rdata;
                        end else begin
                            skid_pc   <= pc;
                            skid_insn <= imem.imem_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        f_valid <= 1'b1;
                        f_pc    <= skid_pc;
                        f_insn  <= skid_insn;
                        state   <= ISSUE;
                    end
                end
                DROP: begin
                    if (imem.imem_rvalid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end
endmodule
